// File: rtl/lcd_line_capture.sv
// ---------------------------------------------------------------------------
// lcd_line_capture
// Sink end of the PPU-to-LCD pixel stream. Pixels arrive one per valid cycle
// and are assembled into LINE_WIDTH-pixel lines. Completed lines are held in a
// ping-pong pair of line buffers and handed to a consumer over valid/ready.
// Line and frame position are tracked. Resync and overflow faults are flagged.
//
// Optional feature macro: LCD_PALETTE_MAP_EN
//   defined   : every pixel is remapped through i_palette (BGP format) before
//               it is stored.
//   undefined : i_px_data is stored unmodified and i_palette is ignored.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_px_valid/i_px_data  pixel stream input (one shade per valid cycle)
//   i_px_sol/i_px_sof     start of line / start of frame, qualified by valid
//   i_palette             BGP palette (optional feature only)
//   o_out_valid/i_out_ready  line handshake
//   o_out_line            line number of the presented line
//   o_out_pixels          line data, pixel 0 in the MSBs
//   o_frame_done          pulse when line NUM_LINES-1 is accepted
//   o_sync_err/o_overflow sticky fault flags, cleared by i_clear_err
// ---------------------------------------------------------------------------
module lcd_line_capture #(
  parameter int LINE_WIDTH = 160,
  parameter int NUM_LINES  = 144,
  parameter int PIXEL_BITS = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_px_valid,
  input  logic [PIXEL_BITS-1:0]            i_px_data,
  input  logic                             i_px_sol,
  input  logic                             i_px_sof,
  input  logic [7:0]                       i_palette,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [7:0]                       o_out_line,
  output logic [LINE_WIDTH*PIXEL_BITS-1:0] o_out_pixels,
  output logic                             o_frame_done,
  output logic                             o_sync_err,
  output logic                             o_overflow,
  input  logic                             i_clear_err
);

  localparam int BUF_W = LINE_WIDTH * PIXEL_BITS;
  localparam int X_W   = $clog2(LINE_WIDTH);
  localparam int Y_W   = $clog2(NUM_LINES);
  localparam int LSB_W = $clog2(BUF_W);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    CAPTURE  = 2'd1,
    WAIT_SOL = 2'd2
  } state_t;

  state_t               r_state;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic                 r_drop;      // current line is being discarded
  logic [BUF_W-1:0]     r_buf [2];
  logic [7:0]           r_tag [2];
  logic [1:0]           r_full;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic                 r_sync_err;
  logic                 r_overflow;

  logic                 w_accept;
  logic                 w_wr_full;
  logic                 w_sof;
  logic                 w_start;
  logic                 w_pix;
  logic                 w_last;
  logic                 w_sync_set;
  logic                 w_we;
  logic [X_W-1:0]       w_wr_x;
  logic [LSB_W-1:0]     w_wr_lsb;
  logic [PIXEL_BITS-1:0] w_px;

`ifdef LCD_PALETTE_MAP_EN
  assign w_px = i_palette[int'(i_px_data)*PIXEL_BITS +: PIXEL_BITS];
`else
  logic w_unused_palette;
  assign w_unused_palette = ^i_palette;
  assign w_px = i_px_data;
`endif

  always_comb begin
    w_accept  = r_full[r_rd_ptr] & i_out_ready;
    // A buffer freed by the consumer this very cycle already counts as free.
    w_wr_full = r_full[r_wr_ptr] & ~(w_accept & (r_rd_ptr == r_wr_ptr));
    w_sof     = i_px_valid & i_px_sof;
    // A line begins on SOF anywhere, or on SOL once a frame is in progress
    // (WAIT_SOL normal start, or a mid-line restart from CAPTURE).
    w_start   = w_sof | (i_px_valid & i_px_sol & (r_state != WAIT_SOF));
    w_pix     = i_px_valid & ~w_start & (r_state == CAPTURE);
    w_last    = w_pix & (r_x == X_W'(LINE_WIDTH - 1));
    w_sync_set = (w_sof & (r_state != WAIT_SOF))
               | (i_px_valid & i_px_sol & ~i_px_sof & (r_state == CAPTURE))
               | (i_px_valid & ~i_px_sol & ~i_px_sof & (r_state == WAIT_SOL));
    w_we      = (w_start & ~w_wr_full) | (w_pix & ~r_drop);
    w_wr_x    = w_start ? '0 : r_x;
    w_wr_lsb  = LSB_W'((LINE_WIDTH - 1 - int'(w_wr_x)) * PIXEL_BITS);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= WAIT_SOF;
      r_x        <= '0;
      r_y        <= '0;
      r_drop     <= 1'b0;
      r_full     <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_sync_err <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end

      // Set events are evaluated after the clear so that they win.
      if (i_clear_err) begin
        r_sync_err <= 1'b0;
        r_overflow <= 1'b0;
      end
      if (w_sync_set) r_sync_err <= 1'b1;
      if (w_start & w_wr_full) r_overflow <= 1'b1;

      if (w_we) r_buf[r_wr_ptr][w_wr_lsb +: PIXEL_BITS] <= w_px;

      if (w_start) begin
        // Any partial line is simply abandoned: its buffer was never marked full.
        r_drop  <= w_wr_full;
        r_x     <= X_W'(1);
        r_state <= CAPTURE;
        if (w_sof) r_y <= '0;
      end else if (w_pix) begin
        if (w_last) begin
          r_x <= '0;
          // A dropped line leaves the write pointer on the still-full buffer.
          if (!r_drop) begin
            r_full[r_wr_ptr] <= 1'b1;
            r_tag[r_wr_ptr]  <= 8'(r_y);
            r_wr_ptr         <= ~r_wr_ptr;
          end
          if (r_y == Y_W'(NUM_LINES - 1)) begin
            r_y     <= '0;
            r_state <= WAIT_SOF;
          end else begin
            r_y     <= r_y + 1'b1;
            r_state <= WAIT_SOL;
          end
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign o_out_valid  = r_full[r_rd_ptr];
  assign o_out_line   = r_tag[r_rd_ptr];
  assign o_out_pixels = r_buf[r_rd_ptr];
  assign o_frame_done = w_accept & (r_tag[r_rd_ptr] == 8'(NUM_LINES - 1));
  assign o_sync_err   = r_sync_err;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_lcd_line_capture.sv
// ---------------------------------------------------------------------------
// tb_lcd_line_capture
// Directed bench for lcd_line_capture: full frame, backpressure/overflow,
// mid-line SOL resync, mid-frame SOF resync, stray pixel, error clearing and
// the palette remap (or its absence in the default build).
// ---------------------------------------------------------------------------
module tb_lcd_line_capture;

  localparam int LW = 160;
  localparam int NL = 144;
  typedef logic [LW*2-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       px_valid, px_sol, px_sof;
  logic [1:0] px_data;
  logic [7:0] palette;
  logic       out_valid, out_ready;
  logic [7:0] out_line;
  vec_t       out_pixels;
  logic       frame_done, sync_err, overflow, clear_err;

  lcd_line_capture #(.LINE_WIDTH(LW), .NUM_LINES(NL), .PIXEL_BITS(2)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_px_valid   (px_valid),
    .i_px_data    (px_data),
    .i_px_sol     (px_sol),
    .i_px_sof     (px_sof),
    .i_palette    (palette),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_line   (out_line),
    .o_out_pixels (out_pixels),
    .o_frame_done (frame_done),
    .o_sync_err   (sync_err),
    .o_overflow   (overflow),
    .i_clear_err  (clear_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int   q_line[$];
  vec_t q_pix[$];
  int   q_fd[$];
  int   q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer monitor: records every completed handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_line.push_back(int'(out_line));
      q_pix.push_back(out_pixels);
      q_fd.push_back(int'(frame_done));
      q_cyc.push_back(cyc);
      $display("xfer: line=%0d frame_done=%0b cycle=%0d", out_line, frame_done, cyc);
    end
  end

  task automatic check_eq(input string tag, input vec_t obs, input vec_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Line with px_data = (x+b)%4, pixel 0 in the MSBs (hand-computed bytes).
  function automatic vec_t pat(input int b);
    case (b % 4)
      0:       return {40{8'h1B}};
      1:       return {40{8'h6C}};
      2:       return {40{8'hB1}};
      default: return {40{8'hC6}};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] d, input logic sol, input logic sof);
    @(posedge clk); #1;
    px_valid = v; px_data = d; px_sol = sol; px_sof = sof;
  endtask

  task automatic send_line(input int b, input logic sof, input int stop_at);
    for (int x = 0; x < stop_at; x++)
      drive(1'b1, 2'((x + b) % 4), x == 0, sof && (x == 0));
    drive(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic flush_q();
    q_line.delete(); q_pix.delete(); q_fd.delete(); q_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd_sum;
    rst = 1'b1; px_valid = 0; px_data = 0; px_sol = 0; px_sof = 0;
    palette = 8'hE4; out_ready = 1'b0; clear_err = 1'b0;

    // ---- reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid", vec_t'(out_valid), vec_t'(0));
    check_eq("rst_line", vec_t'(out_line), vec_t'(0));
    check_eq("rst_pixels", out_pixels, vec_t'(0));
    check_eq("rst_flags", vec_t'({frame_done, sync_err, overflow}), vec_t'(0));
    @(posedge clk); #1 rst = 1'b0;

    // ---- full frame, consumer always ready
    out_ready = 1'b1;
    for (int y = 0; y < NL; y++) send_line(0, y == 0, LW);
    drain();
    check_eq("ff_count", vec_t'(q_line.size()), vec_t'(NL));
    fd_sum = 0;
    for (int i = 0; i < q_line.size(); i++) begin
      check_eq($sformatf("ff_line%0d", i), vec_t'(q_line[i]), vec_t'(i));
      check_eq($sformatf("ff_pix%0d", i), q_pix[i], pat(0));
      fd_sum += q_fd[i];
    end
    check_eq("ff_fd_count", vec_t'(fd_sum), vec_t'(1));
    if (q_fd.size() == NL) check_eq("ff_fd_last", vec_t'(q_fd[NL-1]), vec_t'(1));
    check_eq("ff_flags", vec_t'({sync_err, overflow}), vec_t'(0));
    flush_q();

    // ---- backpressure: three lines with out_ready low
    out_ready = 1'b0;
    for (int x = 0; x < LW - 1; x++) drive(1'b1, 2'((x + 1) % 4), x == 0, x == 0);
    drive(1'b1, 2'((LW - 1 + 1) % 4), 1'b0, 1'b0);
    @(negedge clk);
    check_eq("lat_before", vec_t'(out_valid), vec_t'(0));
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("lat_after", vec_t'(out_valid), vec_t'(1));
    send_line(2, 1'b0, LW);
    send_line(3, 1'b0, LW);
    repeat (3) @(negedge clk);
    check_eq("bp_overflow", vec_t'(overflow), vec_t'(1));
    check_eq("bp_hold_valid", vec_t'(out_valid), vec_t'(1));
    check_eq("bp_hold_line", vec_t'(out_line), vec_t'(0));
    check_eq("bp_hold_pix", out_pixels, pat(1));
    check_eq("bp_no_xfer", vec_t'(q_line.size()), vec_t'(0));
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    check_eq("bp_count", vec_t'(q_line.size()), vec_t'(2));
    if (q_line.size() == 2) begin
      check_eq("bp_line0", vec_t'(q_line[0]), vec_t'(0));
      check_eq("bp_pix0", q_pix[0], pat(1));
      check_eq("bp_line1", vec_t'(q_line[1]), vec_t'(1));
      check_eq("bp_pix1", q_pix[1], pat(2));
      check_eq("bp_b2b", vec_t'(q_cyc[1] - q_cyc[0]), vec_t'(1));
    end
    pulse_clear();
    check_eq("bp_ovf_cleared", vec_t'(overflow), vec_t'(0));
    flush_q();

    // ---- lines 3,4 then mid-line SOL at x=37 on line 5
    send_line(0, 1'b0, LW);
    send_line(0, 1'b0, LW);
    check_eq("ml_sync_before", vec_t'(sync_err), vec_t'(0));
    send_line(0, 1'b0, 37);
    send_line(2, 1'b0, LW);
    drain();
    check_eq("ml_sync", vec_t'(sync_err), vec_t'(1));
    check_eq("ml_count", vec_t'(q_line.size()), vec_t'(3));
    if (q_line.size() == 3) begin
      check_eq("ml_line3", vec_t'(q_line[0]), vec_t'(3));
      check_eq("ml_line5", vec_t'(q_line[2]), vec_t'(5));
      check_eq("ml_pix5", q_pix[2], pat(2));
    end
    pulse_clear();
    flush_q();

    // ---- lines 6..19 then SOF during line 20
    for (int y = 6; y < 20; y++) send_line(0, 1'b0, LW);
    send_line(0, 1'b0, 50);
    send_line(3, 1'b1, LW);
    drain();
    check_eq("sof_sync", vec_t'(sync_err), vec_t'(1));
    check_eq("sof_count", vec_t'(q_line.size()), vec_t'(15));
    if (q_line.size() == 15) begin
      check_eq("sof_line19", vec_t'(q_line[13]), vec_t'(19));
      check_eq("sof_line0", vec_t'(q_line[14]), vec_t'(0));
      check_eq("sof_pix0", q_pix[14], pat(3));
    end
    pulse_clear();
    check_eq("sof_cleared", vec_t'(sync_err), vec_t'(0));
    flush_q();

    // ---- stray pixel in WAIT_SOL, then set-beats-clear
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("stray_sync", vec_t'(sync_err), vec_t'(1));
    @(posedge clk); #1;
    px_valid = 1'b1; px_data = 2'd2; px_sol = 1'b0; px_sof = 1'b0; clear_err = 1'b1;
    @(posedge clk); #1;
    px_valid = 1'b0; clear_err = 1'b0;
    @(negedge clk);
    check_eq("set_wins", vec_t'(sync_err), vec_t'(1));
    pulse_clear();
    check_eq("stray_cleared", vec_t'(sync_err), vec_t'(0));
    send_line(1, 1'b0, LW);
    drain();
    check_eq("stray_count", vec_t'(q_line.size()), vec_t'(1));
    if (q_line.size() == 1) begin
      check_eq("stray_line1", vec_t'(q_line[0]), vec_t'(1));
      check_eq("stray_pix1", q_pix[0], pat(1));
    end
    check_eq("stray_no_err", vec_t'(sync_err), vec_t'(0));
    flush_q();

    // ---- palette: identity then inverted
    palette = 8'hE4;
    send_line(0, 1'b0, LW);
    drain();
    if (q_pix.size() == 1) begin
      check_eq("pal_e4_line", q_pix[0], pat(0));
      check_eq("pal_e4_px0", vec_t'(q_pix[0][LW*2-1 -: 2]), vec_t'(0));
    end else check_eq("pal_e4_count", vec_t'(q_pix.size()), vec_t'(1));
    flush_q();
    palette = 8'h1B;
    send_line(0, 1'b0, LW);
    drain();
    if (q_pix.size() == 1) begin
`ifdef LCD_PALETTE_MAP_EN
      check_eq("pal_1b_line", q_pix[0], {40{8'hE4}});
      check_eq("pal_1b_px0", vec_t'(q_pix[0][LW*2-1 -: 2]), vec_t'(3));
`else
      check_eq("pal_unused_line", q_pix[0], pat(0));
      check_eq("pal_unused_px0", vec_t'(q_pix[0][LW*2-1 -: 2]), vec_t'(0));
`endif
    end else check_eq("pal_1b_count", vec_t'(q_pix.size()), vec_t'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_line_capture.md
Name: lcd_line_capture

Overview:
- Sink end of the PPU-to-LCD pixel stream. Takes one 2-bit shade per valid cycle and assembles each 160-pixel line.
- Completed lines are held in a ping-pong pair of line buffers and handed to a downstream consumer (frame store, PGM dump bench, scaler) through a valid/ready port.
- Tracks line and frame position, and flags resync and overflow faults.

Parameters:
- LINE_WIDTH, 160, pixels per line
- NUM_LINES, 144, lines per frame
- PIXEL_BITS, 2, bits per pixel

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- px_valid  in  1  pixel present this cycle
- px_data  in  PIXEL_BITS  pixel shade index
- px_sol  in  1  start of line; qualified by px_valid, marks pixel x=0
- px_sof  in  1  start of frame; qualified by px_valid, marks x=0,y=0 (px_sol also high)
- palette  in  8  BGP-format palette (used only with the optional feature)
- out_valid  out  1  completed line available
- out_ready  in  1  consumer accepts the line
- out_line  out  8  line number of the presented line
- out_pixels  out  LINE_WIDTH*PIXEL_BITS  line data, pixel 0 in the MSBs
- frame_done  out  1  one-cycle pulse when line NUM_LINES-1 is accepted
- sync_err  out  1  sticky; set on a resync event
- overflow  out  1  sticky; set when a line is dropped
- clear_err  in  1  clears sync_err and overflow

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0, both buffers are marked empty, write x=0, y=0, state WAIT_SOF.
- States:
  - WAIT_SOF: pixels are ignored until px_valid&px_sof, which writes pixel 0 and goes to CAPTURE with x=1, y=0.
  - CAPTURE: each px_valid writes px_data to pixel x of the current write buffer, then x increments.
  - The write at x=LINE_WIDTH-1 marks the buffer full, tagged with y. x returns to 0, y increments, the write buffer toggles, and the state goes to WAIT_SOL. If y was NUM_LINES-1, y wraps to 0 and the state goes to WAIT_SOF.
  - WAIT_SOL: px_valid&px_sol writes pixel 0 and enters CAPTURE. px_valid without px_sol is discarded and sets sync_err.
- Resync: px_valid&px_sof in any state other than WAIT_SOF aborts the partial line (the buffer stays empty), sets sync_err, and restarts at x=0, y=0 using that pixel. px_sol in CAPTURE with x≠0 aborts the partial line, sets sync_err, and restarts the line at x=0 with y unchanged.
- Overflow: if the write buffer is still full when a line must start, every pixel of that line is dropped. Counters still advance, overflow is set, and no line is produced.
- Output side:
  - out_valid is asserted when the read buffer is full; out_pixels and out_line are driven from registers.
  - The handshake completes on out_valid&out_ready. The read buffer is freed and the read pointer toggles.
  - out_valid drops the cycle after acceptance unless the other buffer is already full. In that case it stays high with the new line, so one line per cycle is possible.
  - out_* are held stable while out_valid&!out_ready.
- Latency: the final pixel write at cycle N gives out_valid at N+1.
- Simultaneous events:
  - A buffer freed on the same cycle a line needs it counts as free; no overflow.
  - clear_err and a set event in the same cycle: set wins.
  - frame_done pulses in the acceptance cycle of the line whose out_line=NUM_LINES-1.

Optional Feature:
- LCD_PALETTE_MAP_EN defined: each pixel is remapped before storage. Stored value = palette[2*p+1:2*p], where p=px_data, sampled in the write cycle.
- Not defined: px_data is stored unmodified and the palette port is unused.

Test Plan:
- Full frame: 144 lines of 160 pixels with px_data=x%4 and out_ready=1 -> 144 handshakes, out_line 0..143, pixel pattern 0,1,2,3 repeating, one frame_done after line 143.
- Backpressure: out_ready=0 for 3 lines -> lines 0 and 1 held, line 2 dropped, overflow=1; after release, lines 0 and 1 are delivered intact.
- Mid-line px_sol at x=37 on line 5 -> sync_err=1, line 5 restarts, the next output is line 5 with the new data.
- px_sof during line 20 -> sync_err=1, next delivered out_line=0; clear_err clears the flag.
- Stray pixel in WAIT_SOL -> discarded, sync_err=1, the following line is unaffected.
- LCD_PALETTE_MAP_EN with palette=8'hE4 (identity) and then 8'h1B (inverted) -> pixel 0 stored as 0 and then as 3 respectively.
